// File: rtl/serial_add_ctrl.sv
// Controller for a bit-serial adder. It shifts parallel operands out LSB first,
// collects the registered sum bits and returns them as a parallel result.
//
// state | meaning
// IDLE  | waiting for start; operands latched when start is accepted
// SHIFT | presenting operand bit cnt with en=1; capturing sum bits from cnt=1 on
// DRAIN | en=0, capturing the MSB sum bit and the adder overflow flag
// DONE  | one-cycle done pulse; result/overflow valid
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             a,
  output logic             b,
  output logic             en,
  input  logic             sum_in,
  input  logic             ovf_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] cap_nxt;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sum bits arrive LSB first, so shifting right leaves bit 0 at the bottom
  // after exactly WIDTH captures.
  assign cap_nxt = {sum_in, cap[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_a <= '0;
      sh_b <= '0;
      cap  <= '0;
      cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sh_a <= op_a;
            sh_b <= op_b;
            cap  <= '0;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          if (cnt != LAST) cnt <= cnt + CW'(1);
          if (cnt != '0) cap <= cap_nxt;
        end
        DRAIN: begin
          cap <= cap_nxt;
        end
        default: begin
        end
      endcase
    end
  end

  // Loaded on the DRAIN->DONE edge so the new value is visible together with done.
  always_ff @(posedge clk) begin
    if (reset) begin
      result   <= '0;
      overflow <= 1'b0;
    end else if (state == DRAIN) begin
      result   <= cap_nxt;
      overflow <= ovf_in;
    end
  end

  assign en   = (state == SHIFT);
  assign a    = en & sh_a[0];
  assign b    = en & sh_b[0];
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
